// File: rtl/sla_seq_ctrl.sv
// sla_seq_ctrl: multi-cycle shift-left-arithmetic execution unit.
// Accepts (a, b) when ready, applies one 1-bit left shift per clock for
// b[SHAMT_W-1:0] clocks, then pulses done for one cycle with out/ovf valid.
//
// Handshake: start is sampled only on a rising edge where ready=1. A start
// seen while ready=0 is dropped, never queued. done is a one-cycle pulse;
// out and ovf stay stable from done until the next accepted start.
module sla_seq_ctrl #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             ovf
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t               state_q;
  logic [WIDTH-1:0]     acc_q;
  logic [SHAMT_W-1:0]   cnt_q;
  logic                 ovf_q;
  logic [WIDTH-1:0]     out_q;
  logic                 ready_q;
  logic                 busy_q;
  logic                 done_q;

  // Next accumulator value for one shift step; zero-filled at the LSB.
  logic [WIDTH-1:0]     acc_shl_d;
  logic [SHAMT_W-1:0]   shamt_d;

  // One-step shift and the effective shift amount (upper bits of b ignored).
  always_comb begin
    acc_shl_d = {acc_q[WIDTH-2:0], 1'b0};
    shamt_d   = b[SHAMT_W-1:0];
  end

  // Sequencer FSM with registered status outputs; out is loaded on entry to
  // DONE so it already equals acc during the done cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      out_q   <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            acc_q   <= a;
            cnt_q   <= shamt_d;
            ovf_q   <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            if (shamt_d == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              out_q   <= a;
            end else begin
              state_q <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          acc_q <= acc_shl_d;
          cnt_q <= cnt_q - 1'b1;
          // Sign change on this step: the two top bits differ before shifting.
          ovf_q <= ovf_q | (acc_q[WIDTH-1] ^ acc_q[WIDTH-2]);
          if (cnt_q == SHAMT_W'(1)) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            out_q   <= acc_shl_d;
          end
        end
        ST_DONE: begin
          out_q   <= acc_q;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign out   = out_q;
  assign ovf   = ovf_q;

endmodule
